mem_p_stream_reader: RTL and testbench

Read-side sequencer for the wide P-vector memory. It walks a contiguous address range of the memory's combinational read port and converts it into a valid/ready stream of full rows (`no_of_units` elements per beat) for the processing units. Each run ends with a one-cycle `finish` pulse. It sits between the P memory and the compute array, and is the consumer-side counterpart of the memory's write port.

---
 rtl/mem_p_stream_reader.sv | 113 +++++++++++
 tb/tb_mem_p_stream_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_p_stream_reader.sv
// Read-side sequencer for the P-vector memory: walks a contiguous row range on the
// combinational read port and emits one registered full row per valid/ready beat.
module mem_p_stream_reader #(
    parameter int element_width          = 64,
    parameter int no_of_units            = 8,
    parameter int memories_address_width = 20
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [memories_address_width-1:0]      base_address,
    input  logic [memories_address_width-1:0]      row_count,
    output logic [memories_address_width-1:0]      read_address,
    input  logic [no_of_units*element_width-1:0]   memory_output,
    output logic [no_of_units*element_width-1:0]   out_data,
    output logic [memories_address_width-1:0]      out_index,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy,
    output logic                                   finish,
    output logic [1:0]                             dbg_state
);

    localparam int DW = no_of_units * element_width;
    localparam int AW = memories_address_width;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   remaining_q, remaining_d;
    logic [AW-1:0]   next_index_q, next_index_d;
    logic [AW-1:0]   index_q, index_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            load;
    logic            accept_start;
    logic            out_free;

    // Handshake: a beat transfers on a cycle where out_valid && out_ready; once
    // raised, out_valid and its data/index hold until that transfer happens.
    assign out_free     = !valid_q || out_ready;
    assign load         = (state_q == STREAM) && out_free && (remaining_q != '0);
    assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        next_index_d = next_index_q;
        index_d      = index_q;
        data_d       = data_q;
        valid_d      = valid_q;

        case (state_q)
            IDLE:   if (accept_start) state_d = STREAM;
            STREAM: if (remaining_q == '0 && out_free) state_d = DONE;
            DONE:   state_d = accept_start ? STREAM : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept_start) begin
            addr_d       = base_address;
            remaining_d  = row_count;
            next_index_d = '0;
        end

        // The memory row for addr_q is captured in the same cycle it is addressed.
        if (load) begin
            data_d       = memory_output;
            index_d      = next_index_q;
            valid_d      = 1'b1;
            addr_d       = addr_q + 1'b1;
            remaining_d  = remaining_q - 1'b1;
            next_index_d = next_index_q + 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            next_index_q <= '0;
            index_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            next_index_q <= next_index_d;
            index_q      <= index_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
        end
    end

    assign read_address = addr_q;
    assign out_data     = data_q;
    assign out_index    = index_q;
    assign out_valid    = valid_q;
    assign busy         = (state_q == STREAM);
    assign finish       = (state_q == DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_p_stream_reader.sv
// Bench for mem_p_stream_reader: directed runs against a row-equals-address memory,
// with a queue scoreboard checking every accepted beat.
module tb_mem_p_stream_reader;

    localparam int AW = 20;
    localparam int DW = 512;
    localparam int EW = AW + DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  base_address = '0;
    logic [AW-1:0]  row_count = '0;
    logic [AW-1:0]  read_address;
    logic [DW-1:0]  memory_output;
    logic [DW-1:0]  out_data;
    logic [AW-1:0]  out_index;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           busy;
    logic           finish;
    logic [1:0]     dbg_state;

    logic           start_w = 1'b0;
    logic [3:0]     base_w = '0;
    logic [3:0]     count_w = '0;
    logic [3:0]     read_address_w;
    logic [15:0]    memory_output_w;
    logic [15:0]    out_data_w;
    logic [3:0]     out_index_w;
    logic           out_valid_w;
    logic           busy_w;
    logic           finish_w;
    logic [1:0]     dbg_state_w;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] row(input logic [AW-1:0] a);
        return {8{{44{1'b0}}, a}};
    endfunction

    assign memory_output   = row(read_address);
    assign memory_output_w = {2{4'b0000, read_address_w}};

    mem_p_stream_reader u_dut (
        .clk(clk), .rst(rst), .start(start),
        .base_address(base_address), .row_count(row_count),
        .read_address(read_address), .memory_output(memory_output),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .finish(finish), .dbg_state(dbg_state)
    );

    mem_p_stream_reader #(
        .element_width(8), .no_of_units(2), .memories_address_width(4)
    ) u_wrap (
        .clk(clk), .rst(rst), .start(start_w),
        .base_address(base_w), .row_count(count_w),
        .read_address(read_address_w), .memory_output(memory_output_w),
        .out_data(out_data_w), .out_index(out_index_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .busy(busy_w), .finish(finish_w), .dbg_state(dbg_state_w)
    );

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] idx;
            a   = base + AW'(i);
            idx = AW'(i);
            exp_q.push_back({idx, row(a)});
        end
    endtask

    // Drive inputs just after the rising edge, return at the falling edge for sampling.
    task automatic step(input logic s, input logic r);
        @(posedge clk);
        #1;
        start     = s;
        out_ready = r;
        @(negedge clk);
    endtask

    logic          stall_q = 1'b0;
    logic [EW-1:0] held_q = '0;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_beat", {out_index, out_data}, held_q);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual_index=%0d required=no beat", out_index);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("beat", {out_index, out_data}, e);
                end
            end
            stall_q = out_valid && !out_ready;
            held_q  = {out_index, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat[6];
        int hs, last_hs, fins, fin_c;
        logic [3:0] wa[4];
        pat = '{1, 0, 0, 1, 0, 1};
        wa  = '{4'd14, 4'd15, 4'd0, 4'd1};

        // Reset values while reset is held.
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", read_address, '0);
        chk("rst_data", out_data, '0);
        chk("rst_index", out_index, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic run: base 10, four rows, consumer always ready.
        base_address = 20'd10;
        row_count    = 20'd4;
        push_run(20'd10, 4);
        step(1'b1, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 1'b1);
            if (c == 1) chk("basic_addr_c1", read_address, 20'd10);
            chk("basic_valid", out_valid, (c >= 2 && c <= 5));
            chk("basic_finish", finish, (c == 6));
            chk("basic_busy", busy, (c >= 1 && c <= 5));
        end

        // Backpressure: five rows under a toggling ready pattern.
        base_address = 20'd40;
        row_count    = 20'd5;
        push_run(20'd40, 5);
        step(1'b1, 1'b1);
        hs = 0; last_hs = -1; fins = 0; fin_c = -1;
        for (int c = 1; c <= 40; c++) begin
            step(1'b0, pat[c % 6] != 0);
            if (out_valid && out_ready) begin
                hs++;
                if (hs == 5) last_hs = c;
            end
            if (finish) begin
                fins++;
                fin_c = c;
            end
        end
        chk("bp_beats", hs, 5);
        chk("bp_finish_count", fins, 1);
        chk("bp_finish_cycle", fin_c, last_hs + 1);

        // Zero-length run.
        base_address = 20'd77;
        row_count    = 20'd0;
        step(1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b1);
            chk("zero_valid", out_valid, 1'b0);
            chk("zero_finish", finish, (c == 2));
        end

        // Reset mid-run after two of six beats.
        base_address = 20'd100;
        row_count    = 20'd6;
        push_run(20'd100, 6);
        step(1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) step(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_finish", finish, 1'b0);
        chk("mid_rst_addr", read_address, '0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_index", out_index, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step(1'b0, 1'b1);
            chk("post_rst_finish", finish, 1'b0);
            chk("post_rst_valid", out_valid, 1'b0);
        end
        base_address = 20'd200;
        row_count    = 20'd3;
        push_run(20'd200, 3);
        step(1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 1'b1);
            chk("restart_valid", out_valid, (c >= 2 && c <= 4));
            chk("restart_finish", finish, (c == 5));
        end

        // Stray starts during STREAM, then back-to-back start in the finish cycle.
        base_address = 20'd50;
        row_count    = 20'd4;
        push_run(20'd50, 4);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        base_address = 20'd300;
        row_count    = 20'd7;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("b2b_valid_c5", out_valid, 1'b1);
        base_address = 20'd60;
        row_count    = 20'd2;
        push_run(20'd60, 2);
        step(1'b1, 1'b1);
        chk("b2b_finish_c6", finish, 1'b1);
        step(1'b0, 1'b1);
        chk("b2b_busy_c7", busy, 1'b1);
        chk("b2b_valid_c7", out_valid, 1'b0);
        chk("b2b_addr_c7", read_address, 20'd60);
        step(1'b0, 1'b1);
        chk("b2b_valid_c8", out_valid, 1'b1);
        chk("b2b_index_c8", out_index, 20'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("b2b_finish_c10", finish, 1'b1);
        step(1'b0, 1'b1);
        chk("b2b_idle_c11", finish, 1'b0);

        // Address wrap on a 4-bit instance: base 14, four rows.
        base_w  = 4'd14;
        count_w = 4'd4;
        @(posedge clk);
        #1;
        start_w = 1'b1;
        @(posedge clk);
        #1;
        start_w = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) chk("wrap_addr", read_address_w, wa[c-1]);
            if (c >= 2 && c <= 5) begin
                chk("wrap_valid", out_valid_w, 1'b1);
                chk("wrap_index", out_index_w, 4'(c - 2));
                chk("wrap_data", out_data_w, {2{4'b0000, wa[c-2]}});
            end
            chk("wrap_finish", finish_w, (c == 6));
            step(1'b0, 1'b1);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
